// File: rtl/pinaipple_bus_pkg.sv
// Shared definitions for the PinAIpple peripheral/data bus.
//   - bus_device_e : device port indices (Ram .. SimCtrl)
//   - bus_host_e   : host port indices
//   - *_START/*_SIZE/*_MASK : address regions; a region matches when
//     (addr & MASK) == START
//   - DEV_BASE / DEV_MASK : region tables indexed by bus_device_e
package pinaipple_bus_pkg;

  localparam int unsigned NUM_DEVICES = 6;
  localparam int unsigned NUM_HOSTS   = 2;

  typedef enum int unsigned {
    Ram     = 0,
    Gpio    = 1,
    Uart    = 2,
    Timer   = 3,
    Fraise  = 4,
    SimCtrl = 5
  } bus_device_e;

  typedef enum int unsigned {
    HostCore = 0,
    HostDbg  = 1
  } bus_host_e;

  localparam logic [31:0] RAM_START     = 32'h0010_0000;
  localparam logic [31:0] RAM_SIZE      = 32'h0010_0000;
  localparam logic [31:0] RAM_MASK      = ~(RAM_SIZE - 32'd1);

  localparam logic [31:0] GPIO_START    = 32'h8000_0000;
  localparam logic [31:0] GPIO_SIZE     = 32'h0000_1000;
  localparam logic [31:0] GPIO_MASK     = ~(GPIO_SIZE - 32'd1);

  localparam logic [31:0] UART_START    = 32'h8000_1000;
  localparam logic [31:0] UART_SIZE     = 32'h0000_1000;
  localparam logic [31:0] UART_MASK     = ~(UART_SIZE - 32'd1);

  localparam logic [31:0] TIMER_START   = 32'h8000_2000;
  localparam logic [31:0] TIMER_SIZE    = 32'h0000_1000;
  localparam logic [31:0] TIMER_MASK    = ~(TIMER_SIZE - 32'd1);

  localparam logic [31:0] FRAISE_START  = 32'h8000_3000;
  localparam logic [31:0] FRAISE_SIZE   = 32'h0000_1000;
  localparam logic [31:0] FRAISE_MASK   = ~(FRAISE_SIZE - 32'd1);

  localparam logic [31:0] SIMCTRL_START = 32'h0002_0000;
  localparam logic [31:0] SIMCTRL_SIZE  = 32'h0000_0400;
  localparam logic [31:0] SIMCTRL_MASK  = ~(SIMCTRL_SIZE - 32'd1);

  // Element [0] is Ram, element [5] is SimCtrl.
  localparam logic [NUM_DEVICES-1:0][31:0] DEV_BASE = {
    SIMCTRL_START, FRAISE_START, TIMER_START, UART_START, GPIO_START, RAM_START
  };
  localparam logic [NUM_DEVICES-1:0][31:0] DEV_MASK = {
    SIMCTRL_MASK, FRAISE_MASK, TIMER_MASK, UART_MASK, GPIO_MASK, RAM_MASK
  };

endpackage

// File: rtl/pinaipple_id_fifo.sv
// Small FIFO of host IDs, one per crossbar target, remembering which host
// owns each outstanding request so responses can be routed in order.
// Ports:
//   clk_sys_in / rst_sys_in : clock, async active-low reset
//   push_i, data_i          : enqueue a host ID
//   pop_i                   : dequeue the head (ignored when empty)
//   data_o                  : head entry
//   full_o, empty_o         : occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module pinaipple_id_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_sys_in,
  input  logic             rst_sys_in,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign data_o  = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = ptr_inc(wptr_q);
    if (do_pop)  rptr_d = ptr_inc(rptr_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pinaipple_bus_xbar.sv
// N-host x M-device crossbar for the PinAIpple bus.
// Ports:
//   clk_sys_in / rst_sys_in           : clock, async active-low reset
//   host_req/gnt/addr/we/be/wdata     : host request channel
//   host_rvalid/rdata/err             : host response channel
//   dev_req/gnt/addr/we/be/wdata      : device request channel (winner's fields)
//   dev_rvalid/rdata/err              : device response channel
//
// Handshake: a request is transferred in the cycle where req and gnt are both
// high; req is held with stable fields until gnt. Every transferred request
// gets exactly one rvalid pulse at least one cycle later, in order per target.
// Writes are answered with rvalid too (rdata meaningless).
//
// Target index NumDevices is the internal error responder for unmapped
// addresses: it grants immediately and answers one cycle later with err=1.
// Each target keeps a FIFO of host IDs; a host may only have requests open to
// one target at a time, so responses can never reach a host out of order.
module pinaipple_bus_xbar
  import pinaipple_bus_pkg::*;
#(
  parameter int unsigned NumHosts       = 2,
  parameter int unsigned NumDevices     = 6,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [NumDevices-1:0][DataWidth-1:0] DevBase = DEV_BASE,
  parameter logic [NumDevices-1:0][DataWidth-1:0] DevMask = DEV_MASK
) (
  input  logic                                   clk_sys_in,
  input  logic                                   rst_sys_in,
  input  logic [NumHosts-1:0]                    host_req_i,
  output logic [NumHosts-1:0]                    host_gnt_o,
  input  logic [NumHosts-1:0][DataWidth-1:0]     host_addr_i,
  input  logic [NumHosts-1:0]                    host_we_i,
  input  logic [NumHosts-1:0][DataWidth/8-1:0]   host_be_i,
  input  logic [NumHosts-1:0][DataWidth-1:0]     host_wdata_i,
  output logic [NumHosts-1:0]                    host_rvalid_o,
  output logic [NumHosts-1:0][DataWidth-1:0]     host_rdata_o,
  output logic [NumHosts-1:0]                    host_err_o,
  output logic [NumDevices-1:0]                  dev_req_o,
  input  logic [NumDevices-1:0]                  dev_gnt_i,
  output logic [NumDevices-1:0][DataWidth-1:0]   dev_addr_o,
  output logic [NumDevices-1:0]                  dev_we_o,
  output logic [NumDevices-1:0][DataWidth/8-1:0] dev_be_o,
  output logic [NumDevices-1:0][DataWidth-1:0]   dev_wdata_o,
  input  logic [NumDevices-1:0]                  dev_rvalid_i,
  input  logic [NumDevices-1:0][DataWidth-1:0]   dev_rdata_i,
  input  logic [NumDevices-1:0]                  dev_err_i
);

  localparam int NH     = int'(NumHosts);
  localparam int ND     = int'(NumDevices);
  localparam int NT     = ND + 1;          // devices plus error responder
  localparam int ErrIdx = ND;
  localparam int TW     = $clog2(NT);
  localparam int HW     = (NH > 1) ? $clog2(NH) : 1;
  localparam int CW     = $clog2(MaxOutstanding + 1);

  // Host-side state
  logic [NH-1:0][TW-1:0] tgt;
  logic [NH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NH-1:0][TW-1:0] last_q, last_d;
  logic [NH-1:0]         elig;
  logic [NH-1:0]         host_gnt;
  logic [NH-1:0]         host_rsp;
  logic [NH-1:0]         rsp_dbl;

  // Target-side state (index ErrIdx = error responder)
  logic [NT-1:0][HW-1:0]        ptr_q, ptr_d;
  logic [NT-1:0]                win_valid;
  logic [NT-1:0][HW-1:0]        win_id;
  logic [NT-1:0]                t_gnt, t_rv_raw, t_err, t_pop, t_grant;
  logic [NT-1:0][DataWidth-1:0] t_rdata;
  logic [NT-1:0]                fifo_full, fifo_empty;
  logic [NT-1:0][HW-1:0]        fifo_head;
  logic                         err_rvalid_q, err_rvalid_d;

  function automatic int rr_idx(input int p, input int i);
    return (p + i) % NH;
  endfunction

  // Address decode: lowest-indexed matching region wins.
  always_comb begin
    tgt = '0;
    for (int h = 0; h < NH; h++) begin
      tgt[h] = TW'(ErrIdx);
      for (int d = ND - 1; d >= 0; d--) begin
        if ((host_addr_i[h] & DevMask[d]) == DevBase[d]) tgt[h] = TW'(d);
      end
    end
  end

  // Uniform view of every target, the error responder included.
  always_comb begin
    t_gnt    = '0;
    t_rv_raw = '0;
    t_err    = '0;
    t_rdata  = '0;
    for (int d = 0; d < ND; d++) begin
      t_gnt[d]    = dev_gnt_i[d];
      t_rv_raw[d] = dev_rvalid_i[d];
      t_err[d]    = dev_err_i[d];
      t_rdata[d]  = dev_rdata_i[d];
    end
    t_gnt[ErrIdx]    = 1'b1;
    t_rv_raw[ErrIdx] = err_rvalid_q;
    t_err[ErrIdx]    = 1'b1;
    t_rdata[ErrIdx]  = '0;
  end

  // A response with an empty ID FIFO has no owner and is dropped.
  assign t_pop   = t_rv_raw & ~fifo_empty;
  assign t_grant = win_valid & t_gnt;

  // Response routing, same cycle as the device rvalid.
  always_comb begin
    host_rsp     = '0;
    rsp_dbl      = '0;
    host_rdata_o = '0;
    host_err_o   = '0;
    for (int d = 0; d < NT; d++) begin
      for (int h = 0; h < NH; h++) begin
        if (t_pop[d] && fifo_head[d] == HW'(h)) begin
          if (host_rsp[h]) rsp_dbl[h] = 1'b1;
          host_rsp[h]     = 1'b1;
          host_rdata_o[h] = t_rdata[d];
          host_err_o[h]   = t_err[d];
        end
      end
    end
  end
  assign host_rvalid_o = host_rsp;

  // Eligibility. A response arriving this cycle frees its slot (both in the
  // host count and in the target FIFO) so a waiting request can go at once.
  always_comb begin
    elig = '0;
    for (int h = 0; h < NH; h++) begin
      logic cnt_ok, eff_zero, fifo_ok;
      cnt_ok   = (cnt_q[h] < CW'(MaxOutstanding)) || host_rsp[h];
      eff_zero = (cnt_q[h] == '0) || (cnt_q[h] == CW'(1) && host_rsp[h]);
      fifo_ok  = !fifo_full[tgt[h]] || t_pop[tgt[h]];
      elig[h]  = host_req_i[h] && cnt_ok && fifo_ok &&
                 (eff_zero || last_q[h] == tgt[h]);
    end
  end

  // Round-robin per target; descending scan so the host closest to the
  // pointer is the last (winning) assignment.
  always_comb begin
    win_valid = '0;
    win_id    = '0;
    for (int d = 0; d < NT; d++) begin
      for (int i = NH - 1; i >= 0; i--) begin
        if (elig[rr_idx(int'(ptr_q[d]), i)] &&
            tgt[rr_idx(int'(ptr_q[d]), i)] == TW'(d)) begin
          win_valid[d] = 1'b1;
          win_id[d]    = HW'(rr_idx(int'(ptr_q[d]), i));
        end
      end
    end
  end

  // Forward the winner's fields to each real device.
  always_comb begin
    dev_req_o   = '0;
    dev_addr_o  = '0;
    dev_we_o    = '0;
    dev_be_o    = '0;
    dev_wdata_o = '0;
    for (int d = 0; d < ND; d++) begin
      if (win_valid[d]) begin
        dev_req_o[d]   = 1'b1;
        dev_addr_o[d]  = host_addr_i[win_id[d]];
        dev_we_o[d]    = host_we_i[win_id[d]];
        dev_be_o[d]    = host_be_i[win_id[d]];
        dev_wdata_o[d] = host_wdata_i[win_id[d]];
      end
    end
  end

  always_comb begin
    host_gnt = '0;
    for (int d = 0; d < NT; d++) begin
      for (int h = 0; h < NH; h++) begin
        if (t_grant[d] && win_id[d] == HW'(h)) host_gnt[h] = 1'b1;
      end
    end
  end
  assign host_gnt_o = host_gnt;

  // Next state: outstanding counts, last target, RR pointers, error responder.
  always_comb begin
    cnt_d        = cnt_q;
    last_d       = last_q;
    ptr_d        = ptr_q;
    err_rvalid_d = t_grant[ErrIdx];
    for (int h = 0; h < NH; h++) begin
      if (host_gnt[h]) last_d[h] = tgt[h];
      if (host_gnt[h] && !host_rsp[h]) begin
        cnt_d[h] = cnt_q[h] + CW'(1);
      end else if (!host_gnt[h] && host_rsp[h] && cnt_q[h] != '0) begin
        cnt_d[h] = cnt_q[h] - CW'(1);
      end
    end
    for (int d = 0; d < NT; d++) begin
      if (t_grant[d]) begin
        ptr_d[d] = (win_id[d] == HW'(NH - 1)) ? '0 : win_id[d] + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      cnt_q        <= '0;
      last_q       <= '0;
      ptr_q        <= '0;
      err_rvalid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      ptr_q        <= ptr_d;
      err_rvalid_q <= err_rvalid_d;
    end
  end

  for (genvar d = 0; d < NT; d++) begin : g_fifo
    pinaipple_id_fifo #(
      .Depth(MaxOutstanding),
      .Width(HW)
    ) u_id_fifo (
      .clk_sys_in(clk_sys_in),
      .rst_sys_in(rst_sys_in),
      .push_i    (t_grant[d]),
      .data_i    (win_id[d]),
      .pop_i     (t_pop[d]),
      .data_o    (fifo_head[d]),
      .full_o    (fifo_full[d]),
      .empty_o   (fifo_empty[d])
    );
  end

`ifndef SYNTHESIS
  logic spurious_rvalid;
  assign spurious_rvalid = |(t_rv_raw[ND-1:0] & fifo_empty[ND-1:0]);

  // A device answered with nothing outstanding.
  assert property (@(posedge clk_sys_in) disable iff (!rst_sys_in)
                   !spurious_rvalid);
  // Two targets answered the same host in one cycle.
  assert property (@(posedge clk_sys_in) disable iff (!rst_sys_in)
                   rsp_dbl == '0);
`endif

endmodule

// File: tb/tb_pinaipple_bus_xbar.sv
module tb_pinaipple_bus_xbar;

  localparam int RAM = 0, GPIO = 1, UART = 2, TIMER = 3, SIMCTRL = 5;

  logic             clk_sys_in;
  logic             rst_sys_in;
  logic [1:0]       host_req;
  logic [1:0]       host_gnt;
  logic [1:0][31:0] host_addr;
  logic [1:0]       host_we;
  logic [1:0][3:0]  host_be;
  logic [1:0][31:0] host_wdata;
  logic [1:0]       host_rvalid;
  logic [1:0][31:0] host_rdata;
  logic [1:0]       host_err;
  logic [5:0]       dev_req;
  logic [5:0]       dev_gnt;
  logic [5:0][31:0] dev_addr;
  logic [5:0]       dev_we;
  logic [5:0][3:0]  dev_be;
  logic [5:0][31:0] dev_wdata;
  logic [5:0]       dev_rvalid;
  logic [5:0][31:0] dev_rdata;
  logic [5:0]       dev_err;

  int n_checks = 0;
  int n_errors = 0;

  pinaipple_bus_xbar dut (
    .clk_sys_in   (clk_sys_in),
    .rst_sys_in   (rst_sys_in),
    .host_req_i   (host_req),
    .host_gnt_o   (host_gnt),
    .host_addr_i  (host_addr),
    .host_we_i    (host_we),
    .host_be_i    (host_be),
    .host_wdata_i (host_wdata),
    .host_rvalid_o(host_rvalid),
    .host_rdata_o (host_rdata),
    .host_err_o   (host_err),
    .dev_req_o    (dev_req),
    .dev_gnt_i    (dev_gnt),
    .dev_addr_o   (dev_addr),
    .dev_we_o     (dev_we),
    .dev_be_o     (dev_be),
    .dev_wdata_o  (dev_wdata),
    .dev_rvalid_i (dev_rvalid),
    .dev_rdata_i  (dev_rdata),
    .dev_err_i    (dev_err)
  );

  // Clock / reset
  initial clk_sys_in = 1'b0;
  always #5 clk_sys_in = ~clk_sys_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge, outputs are
  // sampled 2 units later, well before the next edge.
  task automatic tick();
    @(posedge clk_sys_in);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    host_req   = '0;
    host_addr  = '0;
    host_we    = '0;
    host_be    = '0;
    host_wdata = '0;
    dev_gnt    = '0;
    dev_rvalid = '0;
    dev_rdata  = '0;
    dev_err    = '0;
  endtask

  task automatic host_rd(input int h, input logic [31:0] addr);
    host_req[h]  = 1'b1;
    host_addr[h] = addr;
    host_we[h]   = 1'b0;
    host_be[h]   = 4'hF;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_gnt"},    host_gnt,    0);
    check_eq({tag, "_rvalid"}, host_rvalid, 0);
    check_eq({tag, "_err"},    host_err,    0);
    check_eq({tag, "_devreq"}, dev_req,     0);
  endtask

  initial begin
    rst_sys_in = 1'b0;
    idle();
    repeat (3) @(posedge clk_sys_in);
    #1;
    settle();
    check_quiet("reset");
    check_eq("reset_rdata0", host_rdata[0], 0);
    tick();
    rst_sys_in = 1'b1;

    // 1: single Ram read, one-cycle response
    idle(); host_rd(0, 32'h0010_0010); dev_gnt[RAM] = 1'b1; settle();
    check_eq("t1_gnt",    host_gnt,      2'b01);
    check_eq("t1_devreq", dev_req,       6'b000001);
    check_eq("t1_addr",   dev_addr[RAM], 32'h0010_0010);
    check_eq("t1_be",     dev_be[RAM],   4'hF);
    tick();
    idle(); dev_rvalid[RAM] = 1'b1; dev_rdata[RAM] = 32'hCAFE_F00D; settle();
    check_eq("t1_rvalid", host_rvalid,   2'b01);
    check_eq("t1_rdata",  host_rdata[0], 32'hCAFE_F00D);
    check_eq("t1_err",    host_err,      2'b00);
    tick();
    idle(); settle();
    check_quiet("t1_after");
    tick();

    // 2: both hosts hammer Gpio; host1 writes. Grants alternate, device
    // answers each grant one cycle later.
    for (int k = 0; k < 5; k++) begin
      idle();
      dev_gnt[GPIO] = 1'b1;
      if (k < 4) begin
        host_rd(0, 32'h8000_0000);
        host_rd(1, 32'h8000_0004);
        host_we[1]    = 1'b1;
        host_wdata[1] = 32'h5A5A_5A5A;
      end
      if (k >= 1) begin
        dev_rvalid[GPIO] = 1'b1;
        dev_rdata[GPIO]  = 32'h1000 + 32'(k - 1);
      end
      settle();
      check_eq($sformatf("t2_gnt%0d", k), host_gnt,
               (k < 4) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
      if (k < 4) begin
        check_eq($sformatf("t2_addr%0d", k), dev_addr[GPIO],
                 (k % 2 == 0) ? 32'h8000_0000 : 32'h8000_0004);
        check_eq($sformatf("t2_we%0d", k), dev_we[GPIO], (k % 2 == 0) ? 1'b0 : 1'b1);
        if (k % 2 == 1) check_eq($sformatf("t2_wdata%0d", k), dev_wdata[GPIO], 32'h5A5A_5A5A);
      end
      if (k >= 1) begin
        check_eq($sformatf("t2_rvalid%0d", k), host_rvalid, (k % 2 == 1) ? 2'b01 : 2'b10);
        check_eq($sformatf("t2_rdata%0d", k), host_rdata[(k % 2 == 1) ? 0 : 1],
                 32'h1000 + 32'(k - 1));
      end
      tick();
    end

    // 3: Ram then Uart from host0; Uart waits for the Ram response.
    idle(); host_rd(0, 32'h0010_0000); dev_gnt[RAM] = 1'b1; dev_gnt[UART] = 1'b1; settle();
    check_eq("t3_gnt_ram", host_gnt, 2'b01);
    tick();
    for (int k = 0; k < 2; k++) begin
      idle(); host_rd(0, 32'h8000_1000); dev_gnt[UART] = 1'b1; settle();
      check_eq($sformatf("t3_stall_gnt%0d", k), host_gnt, 2'b00);
      check_eq($sformatf("t3_stall_req%0d", k), dev_req,  6'b000000);
      tick();
    end
    idle(); host_rd(0, 32'h8000_1000); dev_gnt[UART] = 1'b1;
    dev_rvalid[RAM] = 1'b1; dev_rdata[RAM] = 32'h3333_3333; settle();
    check_eq("t3_ram_rvalid", host_rvalid,   2'b01);
    check_eq("t3_ram_rdata",  host_rdata[0], 32'h3333_3333);
    check_eq("t3_uart_gnt",   host_gnt,      2'b01);
    check_eq("t3_uart_req",   dev_req,       6'b000100);
    tick();
    idle(); dev_rvalid[UART] = 1'b1; dev_rdata[UART] = 32'h4444_4444; settle();
    check_eq("t3_uart_rvalid", host_rvalid,   2'b01);
    check_eq("t3_uart_rdata",  host_rdata[0], 32'h4444_4444);
    tick();

    // 4: unmapped address goes to the error responder.
    idle(); host_rd(1, 32'h6000_0000); settle();
    check_eq("t4_gnt",    host_gnt, 2'b10);
    check_eq("t4_devreq", dev_req,  6'b000000);
    tick();
    idle(); settle();
    check_eq("t4_rvalid", host_rvalid,   2'b10);
    check_eq("t4_err",    host_err,      2'b10);
    check_eq("t4_rdata",  host_rdata[1], 32'h0);
    tick();
    idle(); settle();
    check_quiet("t4_after");
    tick();

    // SimCtrl decode
    idle(); host_rd(0, 32'h0002_0004); dev_gnt[SIMCTRL] = 1'b1; settle();
    check_eq("sc_devreq", dev_req,  6'b100000);
    check_eq("sc_gnt",    host_gnt, 2'b01);
    tick();
    idle(); dev_rvalid[SIMCTRL] = 1'b1; dev_rdata[SIMCTRL] = 32'h0000_00AB; settle();
    check_eq("sc_rvalid", host_rvalid,   2'b01);
    check_eq("sc_rdata",  host_rdata[0], 32'h0000_00AB);
    tick();

    // 5: outstanding limit of 2 with a silent Ram.
    for (int k = 0; k < 5; k++) begin
      idle(); host_rd(0, 32'h0010_0020); dev_gnt[RAM] = 1'b1;
      if (k == 3) begin
        dev_rvalid[RAM] = 1'b1;
        dev_rdata[RAM]  = 32'h5555_0000;
      end
      settle();
      check_eq($sformatf("t5_gnt%0d", k), host_gnt,
               (k == 2 || k == 4) ? 2'b00 : 2'b01);
      if (k == 3) check_eq("t5_rvalid", host_rvalid, 2'b01);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      idle(); dev_rvalid[RAM] = 1'b1; settle();
      check_eq($sformatf("t5_drain%0d", k), host_rvalid, 2'b01);
      tick();
    end
    idle(); settle();
    check_eq("t5_empty", host_rvalid, 2'b00);
    tick();

    // 6: reset with two Timer requests in flight.
    for (int k = 0; k < 2; k++) begin
      idle(); host_rd(0, 32'h8000_2000); dev_gnt[TIMER] = 1'b1; settle();
      check_eq($sformatf("t6_gnt%0d", k), host_gnt, 2'b01);
      tick();
    end
    idle(); rst_sys_in = 1'b0; settle();
    check_quiet("t6_in_reset");
    tick();
    tick();
    rst_sys_in = 1'b1;
    host_rd(0, 32'h8000_1000);
    host_rd(1, 32'h8000_2000);
    dev_gnt[UART] = 1'b1; dev_gnt[TIMER] = 1'b1; settle();
    check_eq("t6_post_gnt", host_gnt, 2'b11);
    check_eq("t6_post_req", dev_req,  6'b001100);
    tick();
    idle();
    dev_rvalid[TIMER] = 1'b1; dev_rdata[TIMER] = 32'h6666_6666;
    dev_rvalid[UART]  = 1'b1; dev_rdata[UART]  = 32'h7777_7777;
    settle();
    check_eq("t6_rvalid", host_rvalid,   2'b11);
    check_eq("t6_rdata1", host_rdata[1], 32'h6666_6666);
    check_eq("t6_rdata0", host_rdata[0], 32'h7777_7777);
    tick();
    idle(); settle();
    check_quiet("t6_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pinaipple_bus_xbar.md
Name: pinaipple_bus_xbar

Overview:
- Parametrised N-host × M-device crossbar for the PinAIpple peripheral/data bus.
- Replaces the fixed single-host decode-plus-interconnect: mask/base address decode, per-device round-robin arbitration, per-device in-order response routing, outstanding-transaction limits and an internal error responder for unmapped addresses.
- Host side speaks the ibex data protocol (req/gnt/rvalid/err); device side speaks the same protocol.

Parameters:
- NumHosts, 2, number of host ports (≥1).
- NumDevices, 6, number of device ports (≥1).
- DataWidth, 32, data/address width.
- MaxOutstanding, 2, max un-responded requests per host and per device (≥1).
- DevBase, pinaipple_bus_pkg::DEV_BASE, [NumDevices][DataWidth] region base addresses.
- DevMask, pinaipple_bus_pkg::DEV_MASK, [NumDevices][DataWidth] region masks.

Ports:
- clk_sys_in  in  1  clock
- rst_sys_in  in  1  reset
- host_req_i  in  NumHosts  request
- host_gnt_o  out  NumHosts  grant
- host_addr_i  in  NumHosts×DataWidth  byte address
- host_we_i  in  NumHosts  write enable
- host_be_i  in  NumHosts×DataWidth/8  byte enable
- host_wdata_i  in  NumHosts×DataWidth  write data
- host_rvalid_o  out  NumHosts  response valid
- host_rdata_o  out  NumHosts×DataWidth  read data
- host_err_o  out  NumHosts  error response
- dev_req_o  out  NumDevices  request
- dev_gnt_i  in  NumDevices  device accepts request
- dev_addr_o  out  NumDevices×DataWidth  full address (offset extraction is the device's job)
- dev_we_o / dev_be_o / dev_wdata_o  out  per device  forwarded from the winning host
- dev_rvalid_i  in  NumDevices  response valid
- dev_rdata_i  in  NumDevices×DataWidth  response data
- dev_err_i  in  NumDevices  device error

Behaviour:
- Reset rst_sys_in, asynchronous, active-low; clock clk_sys_in.
- Reset values: all outputs 0; RR pointers = host 0; FIFOs empty; counters 0.
- Decode (combinational):
  - Target = lowest index d with (addr & DevMask[d]) == DevBase[d].
  - No match: target = ERR (internal index NumDevices).
- Eligibility: a host request is eligible only if all of these hold:
  - the host's outstanding count < MaxOutstanding;
  - the host's count is 0, or its last target equals the current target (same-target rule, which keeps responses in order);
  - the target's ID FIFO is not full.
- Arbitration:
  - Per device, round-robin among eligible hosts, starting at the RR pointer.
  - Winner's fields are driven onto dev_*_o combinationally with dev_req_o=1.
  - host_gnt_o = dev_req_o & dev_gnt_i for the winner.
  - On grant, the pointer moves to winner+1 (mod NumHosts). It holds if there is no grant.
- On grant:
  - Push the winner's host ID into the device FIFO.
  - Increment the host's count; record its last target.
  - Same cycle, host_gnt_o=1.
- Response:
  - On dev_rvalid_i[d], pop FIFO d. The popped ID selects the host.
  - That host sees host_rvalid_o=1, with rdata/err from device d, in the same cycle (zero added latency). Its count is decremented.
  - Grant and response for one host in the same cycle: the count stays unchanged (net 0).
- ERR responder:
  - Always grants an eligible request in the cycle presented, subject to its RR and FIFO.
  - Responds exactly one cycle later: rvalid=1, err=1, rdata=0.
- Combinational path from dev_gnt_i to host_gnt_o is permitted. There is no path from host_req_i to dev_rvalid.
- dev_rvalid_i with FIFO d empty (protocol violation): ignored. Simulation-only assertion.
- A host can never receive two responses in one cycle (same-target rule). Assert it.
- Reset mid-operation: all in-flight state discarded; devices are reset by the same rst_sys_in.
- Writes produce a response (rvalid) like reads; rdata is don't-care.

Decomposition:
- pinaipple_bus_pkg holds:
  - bus_device_e (Ram, Gpio, Uart, Timer, Fraise, SimCtrl);
  - NUM_DEVICES;
  - per-device *_START/*_SIZE/*_MASK;
  - DEV_BASE/DEV_MASK arrays;
  - the host index enum.
- Sub-module pinaipple_id_fifo (Depth=MaxOutstanding, Width=$clog2(NumHosts) min 1):
  - push/pop, full/empty;
  - simultaneous push+pop when full is allowed;
  - pop when empty is ignored.

Test Plan:
- Host0 reads 0x00100010 (Ram); device 0 grants, rvalid after 1 cycle with rdata 0xCAFEF00D → host_gnt_o[0]=1 in the request cycle; host_rvalid_o[0]=1, rdata 0xCAFEF00D, err 0 the next cycle.
- Host0 and Host1 both request Gpio (0x80000000) every cycle for 4 grants → grants alternate 0,1,0,1; responses routed to matching hosts in order.
- Host0 reads 0x00100000 then 0x80001000 back-to-back; Ram response delayed 3 cycles → second request not granted until Ram rvalid; then Uart is granted.
- Host1 reads 0x60000000 (unmapped) → granted immediately; next cycle rvalid=1, err=1, rdata=0; no dev_req_o asserted.
- MaxOutstanding=2, Ram never responds → Host0 gets 2 grants, the third is stalled; one rvalid lets the third be granted the same cycle, and the count stays 2.
- Assert rst_sys_in low with 2 outstanding to Timer, release → all outputs 0; the next request is granted with empty FIFOs and is routed correctly.
